// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions, FSM states and the default divisor.
package mmio_uart_pkg;

    localparam logic [3:0] OFF_TXDATA  = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_BAUDDIV = 4'h8;
    localparam logic [3:0] OFF_RSVD    = 4'hC;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [15:0] DEFAULT_DIV_C = 16'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic logic [31:0] status_word(
        input logic full,
        input logic empty,
        input logic busy,
        input logic ovf
    );
        logic [31:0] w;
        w = '0;
        w[STAT_FULL]  = full;
        w[STAT_EMPTY] = empty;
        w[STAT_BUSY]  = busy;
        w[STAT_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with a count-based full/empty; a push while full is
// dropped even if a pop happens on the same edge.
module mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter
// and the frame FSM. Each bit lasts (DIV+1) clocks.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWrite,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hit,
    output logic        tx
);

    uart_state_e state_q, state_d;
    logic [15:0] bauddiv_q, bauddiv_d;
    logic [15:0] div_q, div_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;

    logic [3:0]  offset;
    logic        bus_wr;
    logic        wr_txdata;
    logic        wr_status;
    logic        wr_bauddiv;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        busy;
    logic        bit_end;
    logic        load_frame;
    logic        unused_wdata;

    assign unused_wdata = ^writeData[31:16];

    assign hit        = (dataAddr[31:4] == BASE_ADDR[31:4]);
    assign offset     = dataAddr[3:0];
    assign bus_wr     = reset && memWrite && hit;
    assign wr_txdata  = bus_wr && (offset == OFF_TXDATA);
    assign wr_status  = bus_wr && (offset == OFF_STATUS);
    assign wr_bauddiv = bus_wr && (offset == OFF_BAUDDIV);
    assign busy       = (state_q != ST_IDLE);
    assign bit_end    = (baud_cnt_q == div_q);
    assign tx         = tx_q;

    mmio_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (wr_txdata),
        .pop_i   (fifo_pop),
        .data_i  (writeData[7:0]),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        readData = '0;
        if (hit) begin
            case (offset)
                OFF_STATUS:  readData = status_word(fifo_full, fifo_empty, busy, ovf_q);
                OFF_BAUDDIV: readData = {16'h0000, bauddiv_q};
                default:     readData = '0;
            endcase
        end
    end

    // A new overflow wins over a simultaneous clear.
    always_comb begin
        bauddiv_d = bauddiv_q;
        ovf_d     = ovf_q;
        if (wr_bauddiv) begin
            bauddiv_d = writeData[15:0];
        end
        if (wr_status && writeData[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        load_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    load_frame = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = ST_DATA;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Frame start: the divisor is captured here so later BAUDDIV writes
        // only affect the next frame.
        if (load_frame) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_data;
            div_d      = bauddiv_q;
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = ST_START;
            tx_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bauddiv_q  <= DEFAULT_DIV;
            div_q      <= DEFAULT_DIV;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bauddiv_q  <= bauddiv_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected bytes are queued at write time
// and a line monitor decodes each frame cycle by cycle against them.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_BD = BASE + 32'h8;
    localparam logic [31:0] A_RS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] dataAddr = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        hit;
    logic        tx;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t sb[$];
    int   fstart[$];
    int   cyc = 0;
    int   frames_done = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    mmio_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .memWrite  (memWrite),
        .dataAddr  (dataAddr),
        .writeData (writeData),
        .readData  (readData),
        .hit       (hit),
        .tx        (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        memWrite  = 1'b1;
        dataAddr  = addr;
        writeData = data;
        @(posedge clk);
        #1;
        memWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        dataAddr = addr;
        #1;
        data = readData;
    endtask

    task automatic send(input logic [7:0] b, input int div);
        exp_t e;
        e.data = b;
        e.div  = div;
        sb.push_back(e);
        wr(A_TX, {24'h0, b});
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames_done < target; i++) @(posedge clk);
        #1;
        chk_eq("frames_done", frames_done, target);
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        rd(A_ST, s);
        for (int i = 0; i < budget && s[2]; i++) begin
            @(posedge clk);
            #1;
            rd(A_ST, s);
        end
        chk_eq("idle_status", s, 32'h2);
    endtask

    // Line monitor: decodes every cycle of every bit of each frame.
    exp_t        me;
    logic [9:0]  mbits;
    int          mglitch;
    bit          mabort;
    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (reset && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    chk_eq("rx_unexpected_frame", 32'd1, 32'd0);
                end else begin
                    me = sb.pop_front();
                    fstart.push_back(cyc);
                    mglitch = 0;
                    mabort  = 1'b0;
                    mbits   = '0;
                    for (int b = 0; b < 10; b++) begin
                        for (int c = 0; c <= me.div; c++) begin
                            if (!(b == 0 && c == 0)) @(negedge clk);
                            if (!reset) mabort = 1'b1;
                            if (mabort) break;
                            if (c == 0) mbits[b] = tx;
                            else if (tx !== mbits[b]) mglitch++;
                        end
                        if (mabort) break;
                    end
                    if (!mabort) begin
                        chk_eq("rx_data", {24'h0, mbits[8:1]}, {24'h0, me.data});
                        chk_eq("rx_stop", {31'h0, mbits[9]}, 32'd1);
                        chk_eq("rx_bit_width", mglitch, 32'd0);
                        frames_done++;
                    end
                end
            end
        end
    end

    logic [31:0] r;
    int          base;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_tx_during", {31'h0, tx}, 32'd1);
        reset = 1'b1;
        rd(A_ST, r);
        chk_eq("rst_status", r, 32'h2);
        rd(A_BD, r);
        chk_eq("rst_bauddiv", r, 32'd15);
        chk_eq("rst_hit", {31'h0, hit}, 32'd1);
        chk_eq("rst_tx", {31'h0, tx}, 32'd1);

        // Single 0x55 frame, DIV=3
        wr(A_BD, 32'd3);
        send(8'h55, 3);
        chk_eq("t1_tx_at_write_edge", {31'h0, tx}, 32'd1);
        rd(A_ST, r);
        chk_eq("t1_status_queued", r, 32'h0);
        @(posedge clk);
        #1;
        chk_eq("t1_tx_start", {31'h0, tx}, 32'd0);
        rd(A_ST, r);
        chk_eq("t1_status_busy", r, 32'h6);
        repeat (39) @(posedge clk);
        #1;
        rd(A_ST, r);
        chk_eq("t1_busy_at_39", r, 32'h6);
        @(posedge clk);
        #1;
        rd(A_ST, r);
        chk_eq("t1_idle_at_40", r, 32'h2);
        chk_eq("t1_frames", frames_done, 32'd1);

        // Three back-to-back frames, DIV=0
        wr(A_BD, 32'd0);
        base = fstart.size();
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        wait_frames(4, 200);
        wait_idle(50);
        if (fstart.size() >= base + 3) begin
            chk_eq("t2_gap_1", fstart[base+1] - fstart[base], 32'd10);
            chk_eq("t2_gap_2", fstart[base+2] - fstart[base+1], 32'd10);
        end else begin
            chk_eq("t2_frame_starts", fstart.size() - base, 32'd3);
        end

        // Overflow: six writes, DIV=15, FIFO_DEPTH=4
        wr(A_BD, 32'd15);
        send(8'h11, 15);
        send(8'h22, 15);
        send(8'h33, 15);
        send(8'h44, 15);
        send(8'h55, 15);
        wr(A_TX, 32'hFFFF_FF66);
        rd(A_ST, r);
        chk_eq("t3_status_ovf_full", r, 32'hD);
        wr(A_ST, 32'h8);
        rd(A_ST, r);
        chk_eq("t3_status_cleared", r, 32'h5);
        wait_frames(9, 1200);
        wait_idle(200);

        // BAUDDIV 3 -> 7 mid-frame
        wr(A_BD, 32'd3);
        base = fstart.size();
        send(8'hA5, 3);
        send(8'h3C, 7);
        repeat (10) @(posedge clk);
        #1;
        wr(A_BD, 32'd7);
        rd(A_BD, r);
        chk_eq("t4_bauddiv_rb", r, 32'd7);
        wait_frames(11, 300);
        wait_idle(100);
        if (fstart.size() >= base + 2) begin
            chk_eq("t4_first_len", fstart[base+1] - fstart[base], 32'd40);
        end else begin
            chk_eq("t4_frame_starts", fstart.size() - base, 32'd2);
        end

        // Reset in DATA state, with a bus write during reset
        wr(A_BD, 32'd3);
        send(8'h0F, 3);
        send(8'hF0, 3);
        repeat (12) @(posedge clk);
        #1;
        rd(A_ST, r);
        chk_eq("t5_mid_status", r, 32'h4);
        reset     = 1'b0;
        memWrite  = 1'b1;
        dataAddr  = A_TX;
        writeData = 32'h77;
        sb.delete();
        @(posedge clk);
        #1;
        memWrite = 1'b0;
        reset    = 1'b1;
        chk_eq("t5_tx_after_rst", {31'h0, tx}, 32'd1);
        rd(A_ST, r);
        chk_eq("t5_status_after_rst", r, 32'h2);
        rd(A_BD, r);
        chk_eq("t5_bauddiv_after_rst", r, 32'd15);
        repeat (3) @(posedge clk);
        #1;
        chk_eq("t5_tx_stays_idle", {31'h0, tx}, 32'd1);
        rd(A_ST, r);
        chk_eq("t5_status_stays", r, 32'h2);

        // Read decode and out-of-window accesses
        rd(A_RS, r);
        chk_eq("t6_read_rsvd", r, 32'h0);
        rd(A_TX, r);
        chk_eq("t6_read_txdata", r, 32'h0);
        chk_eq("t6_hit_in", {31'h0, hit}, 32'd1);
        rd(32'h0000_1000, r);
        chk_eq("t6_hit_out", {31'h0, hit}, 32'd0);
        chk_eq("t6_read_out", r, 32'h0);
        wr(32'h1234_5670, 32'h99);
        wr(32'h7FFF_0008, 32'h1);
        wr(A_RS, 32'h5);
        chk_eq("t6_tx_idle", {31'h0, tx}, 32'd1);
        rd(A_ST, r);
        chk_eq("t6_status", r, 32'h2);
        rd(A_BD, r);
        chk_eq("t6_bauddiv", r, 32'd15);
        @(posedge clk);
        #1;
        chk_eq("t6_tx_idle_later", {31'h0, tx}, 32'd1);

        repeat (5) @(posedge clk);
        #1;
        chk_eq("sb_drained", sb.size(), 32'd0);
        chk_eq("frames_total", frames_done, 32'd11);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
